// File: rtl/rp_pio_error_detector_pkg.sv
// Package for the root-port PIO error detector.
// Provides the request-type and completion-status encodings, the field
// bases and offsets of the RP PIO Status register layout, and pio_bit(),
// which maps a request type and an error offset to a status bit index.
package rp_pio_pkg;

    typedef enum logic [1:0] {
        CFG = 2'b00,
        IO  = 2'b01,
        MEM = 2'b10
    } pio_type_e;

    typedef enum logic [2:0] {
        SC  = 3'b000,
        UR  = 3'b001,
        CRS = 3'b010,
        CA  = 3'b100
    } cpl_status_e;

    localparam int unsigned PIO_CFG_BASE = 0;
    localparam int unsigned PIO_IO_BASE  = 8;
    localparam int unsigned PIO_MEM_BASE = 16;
    localparam int unsigned PIO_UR_OFS   = 0;
    localparam int unsigned PIO_CA_OFS   = 1;
    localparam int unsigned PIO_CTO_OFS  = 2;

    // Bit index inside the 32-bit status word for a (type, error) pair.
    function automatic logic [4:0] pio_bit(pio_type_e t, int unsigned ofs);
        int unsigned base;
        case (t)
            CFG:     base = PIO_CFG_BASE;
            IO:      base = PIO_IO_BASE;
            default: base = PIO_MEM_BASE;
        endcase
        return 5'(base + ofs);
    endfunction

endpackage

// File: rtl/rp_pio_error_detector_if.sv
// Request/completion bus between the root-port TLP path and the PIO error
// detector.
//   req_valid/req_type  : new non-posted PIO request (master -> detector)
//   req_ready/req_tag   : free-tag indication and the tag it will receive
//   cpl_valid/cpl_tag/cpl_status : returned completion header fields
interface rp_pio_error_detector_if #(
    parameter int TAG_W = 3
);
    logic             req_valid;
    logic [1:0]       req_type;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic             cpl_valid;
    logic [TAG_W-1:0] cpl_tag;
    logic [2:0]       cpl_status;

    modport master (
        output req_valid, req_type, cpl_valid, cpl_tag, cpl_status,
        input  req_ready, req_tag
    );

    modport slave (
        input  req_valid, req_type, cpl_valid, cpl_tag, cpl_status,
        output req_ready, req_tag
    );
endinterface

// File: rtl/rp_pio_error_detector_tag_timer.sv
// One outstanding-request slot: valid bit, stored request type and a
// completion-timeout counter.
//   alloc        : slot is being allocated this edge (with alloc_type)
//   free_by_cpl  : a completion for this slot is sampled this edge
//   timeout_en   : counter advances only while high
//   valid/pio_type : current slot state
//   expire       : combinational; high in the cycle whose edge times the slot out
module rp_pio_tag_timer
    import rp_pio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      alloc,
    input  pio_type_e alloc_type,
    input  logic      free_by_cpl,
    input  logic      timeout_en,
    output logic      valid,
    output pio_type_e pio_type,
    output logic      expire
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             valid_reg;
    pio_type_e        type_reg;
    logic [CNT_W-1:0] cnt_reg;

    // A completion sampled on the same edge wins over the timeout.
    assign expire   = valid_reg && timeout_en && !free_by_cpl && (cnt_reg == LAST);
    assign valid    = valid_reg;
    assign pio_type = type_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            type_reg  <= CFG;
            cnt_reg   <= '0;
        end else if (alloc) begin
            valid_reg <= 1'b1;
            type_reg  <= alloc_type;
            cnt_reg   <= '0;
        end else if (free_by_cpl || expire) begin
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (valid_reg && timeout_en) begin
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/rp_pio_error_detector.sv
// Root-port PIO error source. Allocates tags to outstanding non-posted
// requests, classifies completions and runs per-tag completion timers.
//   bus             : request/completion interface (slave side)
//   timeout_en      : global timer enable
//   pio_set         : one-cycle set pulses in RP PIO Status layout
//   cpl_unexpected  : pulse for a completion hitting a non-outstanding tag
//   outstanding_cnt : number of valid entries
module rp_pio_error_detector
    import rp_pio_pkg::*;
#(
    parameter int NUM_TAGS       = 8,
    parameter int TAG_W          = $clog2(NUM_TAGS),
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rp_pio_error_detector_if.slave      bus,
    input  logic                        timeout_en,
    output logic [31:0]                 pio_set,
    output logic                        cpl_unexpected,
    output logic [TAG_W:0]              outstanding_cnt
);
    logic [NUM_TAGS-1:0] valid_vec;
    logic [NUM_TAGS-1:0] alloc_vec;
    logic [NUM_TAGS-1:0] cpl_free_vec;
    logic [NUM_TAGS-1:0] expire_vec;
    pio_type_e           type_arr [NUM_TAGS];

    logic             free_found;
    logic [TAG_W-1:0] alloc_tag;
    logic             accept;
    logic             cpl_hit;
    pio_type_e        req_type_mapped;

    logic [31:0]    pio_set_reg,  pio_set_next;
    logic           cpl_unexpected_reg;
    logic [TAG_W:0] outstanding_cnt_reg, outstanding_cnt_next;

    // Lowest-index free tag, taken from the registered valid vector so a
    // tag freed this cycle is only offered from the next cycle.
    always_comb begin
        free_found = 1'b0;
        alloc_tag  = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_found = 1'b1;
                alloc_tag  = TAG_W'(i);
            end
        end
    end

    assign bus.req_ready   = free_found;
    assign bus.req_tag     = alloc_tag;
    assign accept          = bus.req_valid && free_found;
    assign req_type_mapped = (bus.req_type == 2'b11) ? MEM : pio_type_e'(bus.req_type);
    assign cpl_hit         = bus.cpl_valid && valid_vec[bus.cpl_tag];

    generate
        for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
            assign alloc_vec[gi]    = accept  && (alloc_tag   == TAG_W'(gi));
            assign cpl_free_vec[gi] = cpl_hit && (bus.cpl_tag == TAG_W'(gi));

            rp_pio_tag_timer #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
                .CNT_W          (CNT_W)
            ) u_tag_timer (
                .clk         (clk),
                .rst_n       (rst_n),
                .alloc       (alloc_vec[gi]),
                .alloc_type  (req_type_mapped),
                .free_by_cpl (cpl_free_vec[gi]),
                .timeout_en  (timeout_en),
                .valid       (valid_vec[gi]),
                .pio_type    (type_arr[gi]),
                .expire      (expire_vec[gi])
            );
        end
    endgenerate

    // All events of one edge are merged into a single status word.
    always_comb begin
        pio_set_next = '0;
        if (cpl_hit) begin
            case (bus.cpl_status)
                SC, CRS: ;
                CA:      pio_set_next[pio_bit(type_arr[bus.cpl_tag], PIO_CA_OFS)] = 1'b1;
                default: pio_set_next[pio_bit(type_arr[bus.cpl_tag], PIO_UR_OFS)] = 1'b1;
            endcase
        end
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (expire_vec[i]) begin
                pio_set_next[pio_bit(type_arr[i], PIO_CTO_OFS)] = 1'b1;
            end
        end
    end

    always_comb begin
        outstanding_cnt_next = outstanding_cnt_reg + (TAG_W+1)'(accept);
        for (int i = 0; i < NUM_TAGS; i++) begin
            outstanding_cnt_next = outstanding_cnt_next
                                 - (TAG_W+1)'(cpl_free_vec[i] | expire_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pio_set_reg         <= '0;
            cpl_unexpected_reg  <= 1'b0;
            outstanding_cnt_reg <= '0;
        end else begin
            pio_set_reg         <= pio_set_next;
            cpl_unexpected_reg  <= bus.cpl_valid && !valid_vec[bus.cpl_tag];
            outstanding_cnt_reg <= outstanding_cnt_next;
        end
    end

    assign pio_set         = pio_set_reg;
    assign cpl_unexpected  = cpl_unexpected_reg;
    assign outstanding_cnt = outstanding_cnt_reg;
endmodule

// File: tb/tb_rp_pio_error_detector.sv
// Randomized bench for rp_pio_error_detector with a small table-based model
// of outstanding requests (busy flag, request kind, enabled-edge age).
module tb_rp_pio_error_detector;
    localparam int NT      = 8;
    localparam int TW      = 3;
    localparam int TIMEOUT = 16;
    localparam int NCYC    = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        timeout_en;
    logic [31:0] pio_set;
    logic        cpl_unexpected;
    logic [TW:0] outstanding_cnt;

    rp_pio_error_detector_if #(.TAG_W(TW)) bus ();

    rp_pio_error_detector #(
        .NUM_TAGS       (NT),
        .TAG_W          (TW),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .timeout_en      (timeout_en),
        .pio_set         (pio_set),
        .cpl_unexpected  (cpl_unexpected),
        .outstanding_cnt (outstanding_cnt)
    );

    always #5 clk = ~clk;

    // Model state
    bit          busy [NT];
    int          kind [NT];   // 0 cfg, 1 io, 2 mem
    int          age  [NT];   // enabled edges since acceptance
    logic [31:0] exp_set;
    logic        exp_unexp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            busy[t] = 1'b0;
            age[t]  = 0;
            kind[t] = 0;
        end
        exp_set   = '0;
        exp_unexp = 1'b0;
    endtask

    function automatic int n_busy();
        int n = 0;
        for (int t = 0; t < NT; t++) n += int'(busy[t]);
        return n;
    endfunction

    function automatic int lowest_free();
        for (int t = 0; t < NT; t++) if (!busy[t]) return t;
        return -1;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_step(input bit rn, input bit rv, input int rtype, input bit cv,
                              input int ctag, input int cst, input bit ten);
        int grant;
        if (!rn) begin
            model_reset();
            return;
        end
        exp_set   = '0;
        exp_unexp = 1'b0;
        grant     = rv ? lowest_free() : -1;
        if (cv) begin
            if (busy[ctag]) begin
                if (cst == 4)                    exp_set[kind[ctag]*8 + 1] = 1'b1;
                else if (cst != 0 && cst != 2)   exp_set[kind[ctag]*8 + 0] = 1'b1;
                busy[ctag] = 1'b0;
            end else begin
                exp_unexp = 1'b1;
            end
        end
        for (int t = 0; t < NT; t++) begin
            if (busy[t] && ten) begin
                age[t]++;
                if (age[t] == TIMEOUT) begin
                    exp_set[kind[t]*8 + 2] = 1'b1;
                    busy[t] = 1'b0;
                end
            end
        end
        if (grant >= 0) begin
            busy[grant] = 1'b1;
            kind[grant] = (rtype == 3) ? 2 : rtype;
            age[grant]  = 0;
        end
    endtask

    initial begin
        bit rn, rv, cv, ten;
        int rtype, ctag, cst, p_req, p_cpl, p_ten, sel, lf;
        int st_tab [6];
        st_tab = '{0, 1, 2, 4, 3, 7};

        rst_n = 1'b0; timeout_en = 1'b0;
        bus.req_valid = 1'b0; bus.req_type = 2'b00;
        bus.cpl_valid = 1'b0; bus.cpl_tag = '0; bus.cpl_status = 3'b000;
        model_reset();
        repeat (2) @(posedge clk);

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            lf = lowest_free();
            chk("pio_set",         pio_set,                exp_set);
            chk("cpl_unexpected",  32'(cpl_unexpected),    32'(exp_unexp));
            chk("outstanding_cnt", 32'(outstanding_cnt),   32'(n_busy()));
            chk("req_ready",       32'(bus.req_ready),     32'(lf >= 0));
            if (lf >= 0) chk("req_tag", 32'(bus.req_tag), 32'(lf));

            if (cyc < 1500)      begin p_req = 20; p_cpl = 15; p_ten = 100; end
            else if (cyc < 3000) begin p_req = 80; p_cpl = 10; p_ten = 80;  end
            else                 begin p_req = 40; p_cpl = 20; p_ten = 30;  end

            rn    = !((cyc == 2000) || ($urandom_range(999) < 3));
            rv    = ($urandom_range(99) < p_req);
            rtype = $urandom_range(3);
            ten   = ($urandom_range(99) < p_ten);
            cv    = ($urandom_range(99) < p_cpl);
            cst   = st_tab[$urandom_range(5)];
            ctag  = $urandom_range(NT - 1);
            sel   = $urandom_range(99);
            for (int t = 0; t < NT; t++) begin
                // Aim completions at tags that are about to time out, and
                // otherwise mostly at outstanding tags.
                if (ten && busy[t] && age[t] == TIMEOUT - 1 && sel < 50) begin
                    cv = 1'b1; ctag = t; cst = 0;
                end
            end
            if (cv && !busy[ctag] && sel >= 50 && sel < 85) begin
                for (int t = 0; t < NT; t++) if (busy[t]) ctag = t;
            end

            rst_n          = rn;
            bus.req_valid  = rv;
            bus.req_type   = 2'(rtype);
            timeout_en     = ten;
            bus.cpl_valid  = cv;
            bus.cpl_tag    = TW'(ctag);
            bus.cpl_status = 3'(cst);
            model_step(rn, rv, rtype, cv, ctag, cst, ten);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
